// File: rtl/mul_div_unit_if.sv
// Execute-stage handshake and HI/LO bus between the pipeline and mul_div_unit.
// The pipeline side drives requests and MTHI/MTLO writes; the unit returns status and HI/LO.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, flush, a, b, hi_we, lo_we, wdata,
        input  stall, busy, done, hi, lo
    );

    modport slave (
        input  start, op, flush, a, b, hi_we, lo_we, wdata,
        output stall, busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers: one shift-add or restoring
// subtract step per cycle on operand magnitudes, sign fix-up on the commit edge.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mul_div_unit_if.slave bus
);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH+1:0] div_trial;
    logic             div_ok;
    logic [W2-1:0]    step_next;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    always_comb begin
        a_neg = ~bus.op[0] & bus.a[WIDTH-1];
        b_neg = ~bus.op[0] & bus.b[WIDTH-1];
        a_mag = a_neg ? -bus.a : bus.a;
        b_mag = b_neg ? -bus.b : bus.b;

        // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
        mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
        div_trial = {1'b0, acc_q[W2-1:WIDTH], acc_q[WIDTH-1]} - {2'b00, opb_q};
        div_ok    = ~div_trial[WIDTH+1];
        if (is_div_q) begin
            step_next = {(div_ok ? div_trial[WIDTH-1:0] : acc_q[W2-2:WIDTH-1]),
                         acc_q[WIDTH-2:0], div_ok};
        end else begin
            step_next = {mul_sum, acc_q[WIDTH-1:1]};
        end

        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rneg_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        hi_d     = bus.hi_we ? bus.wdata : hi_q;
        lo_d     = bus.lo_we ? bus.wdata : lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    state_d  = S_BUSY;
                    cnt_d    = '0;
                    acc_d    = {{WIDTH{1'b0}}, a_mag};
                    opb_d    = b_mag;
                    is_div_d = bus.op[1];
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                end
            end
            S_BUSY: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d = S_DONE;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[W2-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end else begin
                    acc_d = step_next;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
        end
    end

    assign bus.busy  = (state_q == S_BUSY);
    assign bus.done  = (state_q == S_DONE);
    assign bus.stall = bus.busy | (bus.start & ~bus.done);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule
